check_queue: RTL

Parametrised successor to the single-register check stage between decode stage 2 and scheduler 1. It holds a DEPTH-entry queue with valid/ready handshakes on both sides and freezes on STALL/MEM_WAIT. Entries whose immediate is all-ones are classified as UNIMP at push time and rewritten, or trapped when configured, at the scheduler-side output. The queue decouples decode from scheduler back-pressure without losing instructions.

---
 rtl/check_queue_if.sv | 42 ++++
 rtl/check_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/check_queue_if.sv
// Decode-side and scheduler-side handshake bundle for check_queue.
// slave = the queue itself, master = whoever drives decode and consumes the head.
interface check_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             IN_VALID;
  logic             IN_READY;
  logic [XLEN-1:0]  PC;
  logic [16:0]      OPCODE;
  logic [4:0]       RD;
  logic [4:0]       RS1;
  logic [4:0]       RS2;
  logic [XLEN-1:0]  IMM;

  logic             CHECK_VALID;
  logic             CHECK_READY;
  logic [XLEN-1:0]  CHECK_PC;
  logic [16:0]      CHECK_OPCODE;
  logic [4:0]       CHECK_RD;
  logic [4:0]       CHECK_RS1;
  logic [4:0]       CHECK_RS2;
  logic [11:0]      CHECK_CSR;
  logic [XLEN-1:0]  CHECK_IMM;
  logic             CHECK_TRAP;
  logic [3:0]       CHECK_TRAP_CAUSE;
  logic [CNT_W-1:0] CHECK_COUNT;

  modport slave (
    input  IN_VALID, PC, OPCODE, RD, RS1, RS2, IMM, CHECK_READY,
    output IN_READY, CHECK_VALID, CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_RS1,
           CHECK_RS2, CHECK_CSR, CHECK_IMM, CHECK_TRAP, CHECK_TRAP_CAUSE, CHECK_COUNT
  );

  modport master (
    output IN_VALID, PC, OPCODE, RD, RS1, RS2, IMM, CHECK_READY,
    input  IN_READY, CHECK_VALID, CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_RS1,
           CHECK_RS2, CHECK_CSR, CHECK_IMM, CHECK_TRAP, CHECK_TRAP_CAUSE, CHECK_COUNT
  );
endinterface

// File: rtl/check_queue.sv
// DEPTH-entry check queue between decode stage 2 and scheduler 1, frozen by STALL/MEM_WAIT.
// Define CHECK_QUEUE_TRAP_EN to turn UNIMP heads into illegal-instruction traps instead of JAL.
module check_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic           CLK,
  input logic           RST,
  input logic           FLUSH,
  input logic           STALL,
  input logic           MEM_WAIT,
  check_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [16:0]     opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            unimp;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic   hold;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t new_entry;
  entry_t head;

  assign hold  = STALL || MEM_WAIT;
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.IN_VALID && bus.IN_READY;
  assign pop   = bus.CHECK_VALID && bus.CHECK_READY && !hold;

  assign bus.IN_READY    = !full && !hold;
  assign bus.CHECK_VALID = !empty;
  assign bus.CHECK_COUNT = count;

  always_comb begin
    new_entry.pc     = bus.PC;
    new_entry.opcode = bus.OPCODE;
    new_entry.rd     = bus.RD;
    new_entry.rs1    = bus.RS1;
    new_entry.rs2    = bus.RS2;
    new_entry.imm    = bus.IMM;
    new_entry.unimp  = (bus.IMM == {XLEN{1'b1}});
  end

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!hold) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty slots are never visible at the outputs.
  always_ff @(posedge CLK) begin
    if (push && !RST && !FLUSH)
      mem[wr_ptr] <= new_entry;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    bus.CHECK_PC         = '0;
    bus.CHECK_OPCODE     = '0;
    bus.CHECK_RD         = '0;
    bus.CHECK_RS1        = '0;
    bus.CHECK_RS2        = '0;
    bus.CHECK_CSR        = '0;
    bus.CHECK_IMM        = '0;
    bus.CHECK_TRAP       = 1'b0;
    bus.CHECK_TRAP_CAUSE = '0;
    if (!empty) begin
      bus.CHECK_PC = head.pc;
      if (head.unimp) begin
`ifdef CHECK_QUEUE_TRAP_EN
        bus.CHECK_TRAP       = 1'b1;
        bus.CHECK_TRAP_CAUSE = 4'd2;
`else
        bus.CHECK_OPCODE     = 17'h0006F;
`endif
      end else begin
        bus.CHECK_OPCODE = head.opcode;
        bus.CHECK_RD     = head.rd;
        bus.CHECK_RS1    = head.rs1;
        bus.CHECK_RS2    = head.rs2;
        bus.CHECK_CSR    = head.imm[11:0];
        bus.CHECK_IMM    = head.imm;
      end
    end
  end
endmodule
